// File: rtl/vce_pkg.sv
// vce_pkg: shared types, LFSR constants and step function for vector_check_engine.
package vce_pkg;
   typedef enum logic [2:0] {IDLE, RST, SETTLE, APPLY, DONE} state_t;
   localparam int LFSR_W = 32;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003;
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
   endfunction
endpackage

// File: rtl/vce_lfsr.sv
// vce_lfsr: 32-bit right-shifting Galois LFSR with synchronous load and step.
module vce_lfsr
   import vce_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RST_VAL = 32'h1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] value
);
   logic [LFSR_W-1:0] value_q, value_d;
   always_comb value_d = load ? seed : step ? lfsr_step(value_q) : value_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) value_q <= RST_VAL;
      else value_q <= value_d;
   assign value = value_q;
endmodule

// File: rtl/vector_check_engine.sv
// vector_check_engine: drives LFSR stimulus into a golden/netlist DUT pair and counts response mismatches.
// Define VCE_MISMATCH_LOG_EN to capture both responses of the first mismatching vector.
module vector_check_engine
   import vce_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter int          NUM_VECTORS = 1000,
   parameter int          HOLD_CYCLES = 2,
   parameter int          RST_CYCLES  = 2,
   parameter logic [31:0] SEED        = 32'h00000001,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             dut_rst,
   output logic [WIDTH-1:0] stim,
   input  logic [WIDTH-1:0] resp_golden,
   input  logic [WIDTH-1:0] resp_dut,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_idx,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [WIDTH-1:0] first_fail_golden,
   output logic [WIDTH-1:0] first_fail_dut
);
   localparam logic [LFSR_W-1:0] SEED_C = (SEED == '0) ? 32'h1 : SEED;
   localparam logic [31:0] HC1 = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] RC1 = 32'(RST_CYCLES - 1);
   localparam logic [31:0] NV1 = 32'(NUM_VECTORS - 1);
   state_t state_q, state_d;
   logic [31:0] cnt_q, cnt_d, vcnt_q, vcnt_d;
   logic [CNT_W-1:0] mm_q, mm_d, ffi_q, ffi_d;
   logic [WIDTH-1:0] stim_q, stim_d;
   logic dut_rst_q, dut_rst_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [LFSR_W-1:0] lfsr_val, lfsr_nx;
   logic lfsr_adv, go, last_hold, last_vec, mism, first_hit;
   assign go        = start && (state_q == IDLE || state_q == DONE);
   assign last_hold = cnt_q == HC1;
   assign last_vec  = vcnt_q == NV1;
   assign mism      = resp_golden != resp_dut;
   assign first_hit = state_q == APPLY && last_hold && mism && mm_q == '0;
   assign lfsr_nx   = lfsr_step(lfsr_val);
   vce_lfsr #(.RST_VAL(SEED_C)) u_lfsr (
      .clk(clk), .rst(rst), .load(go), .step(lfsr_adv), .seed(SEED_C), .value(lfsr_val)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      vcnt_d = vcnt_q;
      mm_d = mm_q;
      ffi_d = ffi_q;
      stim_d = stim_q;
      dut_rst_d = dut_rst_q;
      busy_d = busy_q;
      done_d = done_q;
      pass_d = pass_q;
      lfsr_adv = 1'b0;
      case (state_q)
         IDLE, DONE: if (go) begin
            state_d = RST;
            cnt_d = '0;
            vcnt_d = '0;
            mm_d = '0;
            ffi_d = '0;
            stim_d = '0;
            dut_rst_d = 1'b1;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
         end
         RST: begin
            cnt_d = (cnt_q == RC1) ? '0 : cnt_q + 32'd1;
            state_d = (cnt_q == RC1) ? SETTLE : RST;
            dut_rst_d = cnt_q != RC1;
         end
         SETTLE: begin
            state_d = APPLY;
            stim_d = lfsr_val[WIDTH-1:0];
         end
         APPLY: begin
            cnt_d = last_hold ? '0 : cnt_q + 32'd1;
            if (last_hold && mism) mm_d = &mm_q ? mm_q : mm_q + 1'b1;
            if (first_hit) ffi_d = vcnt_q[CNT_W-1:0];
            // The final vector leaves stim and vec_idx on the last applied vector.
            if (last_hold && last_vec) begin
               state_d = DONE;
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = ~|mm_d;
            end else if (last_hold) begin
               vcnt_d = vcnt_q + 32'd1;
               lfsr_adv = 1'b1;
               stim_d = lfsr_nx[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         vcnt_q <= '0;
         mm_q <= '0;
         ffi_q <= '0;
         stim_q <= '0;
         dut_rst_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         vcnt_q <= vcnt_d;
         mm_q <= mm_d;
         ffi_q <= ffi_d;
         stim_q <= stim_d;
         dut_rst_q <= dut_rst_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
      end
`ifdef VCE_MISMATCH_LOG_EN
   logic [WIDTH-1:0] ffg_q, ffg_d, ffd_q, ffd_d;
   always_comb begin
      ffg_d = go ? '0 : first_hit ? resp_golden : ffg_q;
      ffd_d = go ? '0 : first_hit ? resp_dut : ffd_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ffg_q <= '0;
         ffd_q <= '0;
      end else begin
         ffg_q <= ffg_d;
         ffd_q <= ffd_d;
      end
   assign first_fail_golden = ffg_q;
   assign first_fail_dut = ffd_q;
`else
   assign first_fail_golden = '0;
   assign first_fail_dut = '0;
`endif
   assign dut_rst = dut_rst_q;
   assign stim = stim_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;
   assign vec_idx = vcnt_q[CNT_W-1:0];
   assign mismatch_cnt = mm_q;
   assign first_fail_idx = ffi_q;
endmodule

// File: doc/vector_check_engine.md
Name: vector_check_engine

Overview:
- Synthesizable self-checking harness for on-board golden-vs-post-route comparison.
- Drives a pseudo-random stimulus bus and a reset into two instances of the design under test (golden and netlist).
- Compares their response buses each vector, counts mismatches and reports pass/fail.
- Hardware counterpart of the bench-side compare loop; sits between the board control logic and the DUT pair.

Parameters:
- WIDTH, 32: stimulus/response bus width, legal range 1..32.
- NUM_VECTORS, 1000: number of vectors per run, at least 1.
- HOLD_CYCLES, 2: cycles each vector is held; compare happens at the last hold cycle; at least 1.
- RST_CYCLES, 2: cycles dut_rst is asserted at run start; at least 1.
- SEED, 32'h00000001: LFSR seed; 0 is illegal and is forced to 1.
- CNT_W, 16: width of the mismatch counter and vector index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- dut_rst  out  1  active-high reset to both DUT instances.
- stim  out  WIDTH  stimulus to both DUTs.
- resp_golden  in  WIDTH  golden DUT output.
- resp_dut  in  WIDTH  post-route DUT output.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start.
- pass  out  1  valid when done; 1 iff mismatch_cnt==0.
- vec_idx  out  CNT_W  index of the vector currently applied.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- first_fail_idx  out  CNT_W  index of the first mismatching vector; valid when mismatch_cnt!=0.
- first_fail_golden  out  WIDTH  see Optional Feature.
- first_fail_dut  out  WIDTH  see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, stim=0, dut_rst=1.
  - busy, done, pass, vec_idx, mismatch_cnt, first_fail_* all 0.
  - LFSR loaded with SEED.
- FSM states: IDLE, RST, SETTLE, APPLY, DONE.
- IDLE/DONE:
  - On start: clear counters, done, pass and first_fail_*; reload the LFSR; go to RST.
  - start is ignored in RST, SETTLE and APPLY.
- RST: dut_rst=1, stim=0, busy=1, for RST_CYCLES cycles, then SETTLE.
- SETTLE: dut_rst=0, stim=0, one cycle, then APPLY.
- APPLY:
  - stim = lfsr[WIDTH-1:0], held for HOLD_CYCLES cycles.
  - On the clock edge ending the last hold cycle:
    - If resp_golden != resp_dut, increment mismatch_cnt, saturating at 2^CNT_W-1.
    - On the first mismatch only, capture first_fail_idx=vec_idx.
    - Then advance the LFSR and increment vec_idx.
  - After the compare of vector NUM_VECTORS-1, go to DONE.
- DONE: busy=0, done=1, pass=(mismatch_cnt==0), stim and vec_idx hold last values, dut_rst=0.
- LFSR:
  - 32-bit Galois, right shift: next = (l>>1) ^ (l[0] ? 32'h80200003 : 0).
  - Vector 0 = SEED; vector 1 = step(SEED).
- Latency: done rises RST_CYCLES + 1 + NUM_VECTORS*HOLD_CYCLES cycles after the edge that samples start.
- Mid-run async reset aborts immediately to reset values; no partial result is retained.
- Responses are compared only at the compare edge; glitches in other cycles are ignored.

Optional Feature:
- Macro: VCE_MISMATCH_LOG_EN.
- Defined: on the first mismatch, first_fail_golden and first_fail_dut capture resp_golden and resp_dut; both cleared on start.
- Undefined: both ports are tied to 0 and no capture registers exist.

Decomposition:
- Package vce_pkg:
  - state enum {IDLE,RST,SETTLE,APPLY,DONE}.
  - LFSR_TAPS=32'h80200003.
  - LFSR_W=32.
- One sub-module vce_lfsr (load, step, seed in, 32-bit value out), instanced once in vector_check_engine.

Test Plan:
- Pass run: NUM_VECTORS=4, HOLD_CYCLES=2, resp_golden=resp_dut=f(stim) -> done rises 11 cycles after start, pass=1, mismatch_cnt=0.
- Stimulus sequence: SEED=1 -> stim=0 during RST/SETTLE; vector0=32'h00000001; vector1=32'h80200003; each held exactly 2 cycles.
- Single fault: flip resp_dut bit 5 only while vec_idx==2 -> mismatch_cnt=1, first_fail_idx=2, pass=0. With VCE_MISMATCH_LOG_EN, first_fail_golden^first_fail_dut = 32'h00000020.
- Saturation: CNT_W=4, NUM_VECTORS=14, resp_dut = ~resp_golden -> mismatch_cnt=14. Same with NUM_VECTORS=20 -> mismatch_cnt=15 (saturated), first_fail_idx=0.
- Async reset: assert rst=0 in APPLY at vec_idx=1 -> all outputs return to reset values without waiting for a clock edge. Release, then start -> vector0=SEED again.
- start pulse during APPLY -> ignored, run completes normally. start in DONE -> counters cleared, done falls next cycle, new run begins with vector0=SEED.
